// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin arbiter sharing the data memory between core (m0) and loader (m1)
`timescale 1ns/1ps
module dmem_arbiter #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  input  logic              m1_lock,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  logic              prio;
  logic              locked;
  logic              cmd_owner;
  logic [RD_LAT-1:0] tag_rd;
  logic [RD_LAT-1:0] tag_own;

  // Grant selection: lock gives m1 exclusive ownership, otherwise round-robin on contention
  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    if (rst_n) begin
      if (locked) begin
        m1_gnt = m1_req;
      end else if (m0_req && m1_req) begin
        m0_gnt = ~prio;
        m1_gnt = prio;
      end else begin
        m0_gnt = m0_req;
        m1_gnt = m1_req;
      end
    end
  end

  // Round-robin pointer moves to the loser; lock state follows each accepted m1 request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio   <= 1'b0;
      locked <= 1'b0;
    end else if (m0_gnt) begin
      prio <= 1'b1;
    end else if (m1_gnt) begin
      prio   <= 1'b0;
      locked <= m1_lock;
    end
  end

  // Registered memory command; address and data hold when idle to avoid needless toggling
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cmd_owner <= 1'b0;
    end else begin
      mem_en <= m0_gnt | m1_gnt;
      if (m1_gnt) begin
        mem_we    <= m1_we;
        mem_addr  <= m1_addr;
        mem_wdata <= m1_wdata;
        cmd_owner <= 1'b1;
      end else if (m0_gnt) begin
        mem_we    <= m0_we;
        mem_addr  <= m0_addr;
        mem_wdata <= m0_wdata;
        cmd_owner <= 1'b0;
      end else begin
        mem_we <= 1'b0;
      end
    end
  end

  // Read tag pipeline tracks who issued each read so data returns to the right port in order
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_rd  <= '0;
      tag_own <= '0;
    end else begin
      tag_rd[0]  <= mem_en & ~mem_we;
      tag_own[0] <= cmd_owner;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_rd[i]  <= tag_rd[i-1];
        tag_own[i] <= tag_own[i-1];
      end
    end
  end

  assign m0_rvalid = tag_rd[RD_LAT-1] & ~tag_own[RD_LAT-1];
  assign m1_rvalid = tag_rd[RD_LAT-1] &  tag_own[RD_LAT-1];
  assign m0_rdata  = mem_rdata;
  assign m1_rdata  = mem_rdata;
  assign busy      = mem_en | (|tag_rd);

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - randomized self-checking bench for dmem_arbiter at RD_LAT 1 and 3
`timescale 1ns/1ps
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0, m1_lock = 0;
  logic [16:0] m0_addr = 0, m1_addr = 0;
  logic [31:0] m0_wdata = 0, m1_wdata = 0;

  // index 0: RD_LAT=1 instance, index 1: RD_LAT=3 instance
  logic [1:0]  g0, g1, rv0, rv1, men, mwe, bsy;
  logic [31:0] rd0 [2];
  logic [31:0] rd1 [2];
  logic [16:0] maddr [2];
  logic [31:0] mwdata [2];
  logic [31:0] mrdata [2];

  dmem_arbiter #(.ADDR_W(17), .DATA_W(32), .RD_LAT(1)) u_lat1 (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(g0[0]), .m0_rvalid(rv0[0]), .m0_rdata(rd0[0]),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(g1[0]), .m1_rvalid(rv1[0]), .m1_rdata(rd1[0]), .m1_lock(m1_lock),
    .mem_en(men[0]), .mem_we(mwe[0]), .mem_addr(maddr[0]), .mem_wdata(mwdata[0]),
    .mem_rdata(mrdata[0]), .busy(bsy[0])
  );

  dmem_arbiter #(.ADDR_W(17), .DATA_W(32), .RD_LAT(3)) u_lat3 (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(g0[1]), .m0_rvalid(rv0[1]), .m0_rdata(rd0[1]),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(g1[1]), .m1_rvalid(rv1[1]), .m1_rdata(rd1[1]), .m1_lock(m1_lock),
    .mem_en(men[1]), .mem_we(mwe[1]), .mem_addr(maddr[1]), .mem_wdata(mwdata[1]),
    .mem_rdata(mrdata[1]), .busy(bsy[1])
  );

  // Memories attached to each instance, with the matching read latency
  bit   [31:0] tmem0 [bit [16:0]];
  bit   [31:0] tmem1 [bit [16:0]];
  logic [31:0] pa [1];
  logic [31:0] pb [3];
  assign mrdata[0] = pa[0];
  assign mrdata[1] = pb[2];

  always @(posedge clk) begin
    if (men[0] && mwe[0]) tmem0[maddr[0]] = mwdata[0];
    if (men[1] && mwe[1]) tmem1[maddr[1]] = mwdata[1];
    pa[0] <= (men[0] && !mwe[0]) ? tmem0[maddr[0]] : 32'h0;
    pb[0] <= (men[1] && !mwe[1]) ? tmem1[maddr[1]] : 32'h0;
    pb[1] <= pb[0];
    pb[2] <= pb[1];
  end

  // Reference model: acceptance-ordered memory plus expected read returns per instance
  typedef struct { int due; bit owner; bit [31:0] data; } ret_t;
  ret_t        qa[$];
  ret_t        qb[$];
  bit   [31:0] refmem [bit [16:0]];
  bit          m_prio, m_locked, prev_acc, prev_we, last_g0, last_g1;
  bit   [16:0] hold_addr;
  bit   [31:0] hold_wdata;
  int          cyc;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic preload(input bit [16:0] a, input bit [31:0] d);
    tmem0[a] = d;
    tmem1[a] = d;
    refmem[a] = d;
  endtask

  task automatic step(input bit r0, input bit w0, input bit [16:0] a0, input bit [31:0] d0,
                      input bit r1, input bit w1, input bit [16:0] a1, input bit [31:0] d1,
                      input bit lk);
    bit eg0, eg1, win;
    @(negedge clk);
    rst_n = 1'b1;
    m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1; m1_lock = lk;
    #1;
    if (m_locked) begin
      eg0 = 1'b0; eg1 = r1;
    end else if (r0 && r1) begin
      eg0 = (m_prio == 1'b0); eg1 = (m_prio == 1'b1);
    end else begin
      eg0 = r0; eg1 = r1;
    end
    for (int k = 0; k < 2; k++) begin
      bit   due, exp_busy;
      ret_t e;
      due = 1'b0;
      e = '{0, 1'b0, 32'h0};
      exp_busy = prev_acc || (k == 0 ? qa.size() > 0 : qb.size() > 0);
      if (k == 0 && qa.size() > 0 && qa[0].due == cyc) begin due = 1'b1; e = qa.pop_front(); end
      if (k == 1 && qb.size() > 0 && qb[0].due == cyc) begin due = 1'b1; e = qb.pop_front(); end
      check_eq($sformatf("m0_gnt[%0d]", k), g0[k], eg0);
      check_eq($sformatf("m1_gnt[%0d]", k), g1[k], eg1);
      check_eq($sformatf("mem_en[%0d]", k), men[k], prev_acc);
      check_eq($sformatf("mem_we[%0d]", k), mwe[k], prev_acc && prev_we);
      check_eq($sformatf("mem_addr[%0d]", k), maddr[k], hold_addr);
      check_eq($sformatf("mem_wdata[%0d]", k), mwdata[k], hold_wdata);
      check_eq($sformatf("m0_rvalid[%0d]", k), rv0[k], due && !e.owner);
      check_eq($sformatf("m1_rvalid[%0d]", k), rv1[k], due && e.owner);
      if (due) check_eq($sformatf("rdata[%0d]", k), e.owner ? rd1[k] : rd0[k], e.data);
      check_eq($sformatf("busy[%0d]", k), bsy[k], exp_busy);
    end
    prev_acc = eg0 || eg1;
    if (prev_acc) begin
      win = eg1;
      prev_we    = win ? w1 : w0;
      hold_addr  = win ? a1 : a0;
      hold_wdata = win ? d1 : d0;
      if (prev_we) refmem[hold_addr] = hold_wdata;
      else begin
        qa.push_back('{cyc + 2, win, refmem[hold_addr]});
        qb.push_back('{cyc + 4, win, refmem[hold_addr]});
      end
      m_prio = ~win;
      if (win) m_locked = lk;
    end else begin
      prev_we = 1'b0;
    end
    last_g0 = eg0;
    last_g1 = eg1;
    cyc++;
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    m0_req = 1'b1; m1_req = 1'b1;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      check_eq($sformatf("rst_gnt[%0d]", k), {g0[k], g1[k]}, 2'b00);
      check_eq($sformatf("rst_mem[%0d]", k), {men[k], mwe[k], maddr[k], mwdata[k]}, 64'h0);
      check_eq($sformatf("rst_rv_busy[%0d]", k), {rv0[k], rv1[k], bsy[k]}, 3'b000);
    end
    qa.delete(); qb.delete();
    m_prio = 0; m_locked = 0; prev_acc = 0; prev_we = 0;
    hold_addr = 0; hold_wdata = 0;
    last_g0 = 0; last_g1 = 0;
    cyc++;
  endtask

  function automatic bit [16:0] rnd_addr();
    return ($urandom_range(0, 9) == 0) ? 17'h1FFFF : 17'($urandom_range(0, 7));
  endfunction

  initial begin
    bit          h0, h1, r0, w0, r1, w1, lk;
    bit   [16:0] a0, a1;
    bit   [31:0] d0, d1;
    bit   [5:0]  seq;
    int          n1;
    bit          done;
    cyc = 0;
    reset_pulse();
    reset_pulse();

    // Single m0 read through the RD_LAT=1 instance
    preload(17'h00010, 32'hDEADBEEF);
    step(1, 0, 17'h00010, 0, 0, 0, 0, 0, 0);
    repeat (5) step(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Continuous contention alternates starting with m0 after reset
    reset_pulse();
    seq = 0;
    for (int i = 0; i < 6; i++) begin
      step(1, 0, 17'h20, 0, 1, 0, 17'h21, 0, 0);
      seq = {seq[4:0], last_g1};
    end
    check_eq("alt_order", seq, 6'b010101);
    repeat (5) step(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Write then read-after-write at the top address
    step(0, 0, 0, 0, 1, 1, 17'h1FFFF, 32'h12345678, 0);
    step(1, 0, 17'h1FFFF, 0, 0, 0, 0, 0, 0);
    repeat (5) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check_eq("raw_data", refmem[17'h1FFFF], tmem0[17'h1FFFF]);

    // m1 burst with lock 1,1,0 holds m0 off until the unlocking grant
    n1 = 0;
    done = 0;
    for (int i = 0; i < 12 && !done; i++) begin
      step(1, 0, 17'h5, 0, n1 < 3, 1, 17'(17'h100 + n1), 32'(32'hA0 + n1), n1 < 2);
      if (last_g0) begin
        done = 1;
        check_eq("lock_m1_before_m0", n1, 3);
      end
      if (last_g1) n1++;
    end
    check_eq("lock_m0_granted", done, 1'b1);
    repeat (5) step(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset while a read is in flight discards the return
    step(1, 0, 17'h00010, 0, 0, 0, 0, 0, 0);
    reset_pulse();
    repeat (5) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 17'h3, 0, 1, 0, 17'h4, 0, 0);
    check_eq("post_reset_prio", last_g0, 1'b1);
    repeat (5) step(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Back-to-back reads m0,m1,m0 returned in order
    preload(17'h30, 32'h11111111);
    preload(17'h31, 32'h22222222);
    preload(17'h32, 32'h33333333);
    step(1, 0, 17'h30, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 17'h31, 0, 0);
    step(1, 0, 17'h32, 0, 0, 0, 0, 0, 0);
    repeat (6) step(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Randomized traffic honouring the hold-while-waiting rule
    h0 = 0; h1 = 0;
    r0 = 0; w0 = 0; a0 = 0; d0 = 0; r1 = 0; w1 = 0; a1 = 0; d1 = 0; lk = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!h0) begin
        r0 = $urandom_range(0, 99) < 60; w0 = $urandom_range(0, 1) == 1;
        a0 = rnd_addr(); d0 = $urandom;
      end
      if (!h1) begin
        r1 = $urandom_range(0, 99) < 50; w1 = $urandom_range(0, 1) == 1;
        a1 = rnd_addr(); d1 = $urandom; lk = $urandom_range(0, 9) < 3;
      end
      step(r0, w0, a0, d0, r1, w1, a1, d1, lk);
      h0 = r0 && !last_g0;
      h1 = r1 && !last_g1;
      if ($urandom_range(0, 299) == 0) begin
        reset_pulse();
        h0 = 0; h1 = 0;
      end
    end
    repeat (6) step(0, 0, 0, 0, 0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter that shares the processor's single-port 32-bit data memory between the core load/store unit (port m0) and a program/data loader (port m1).
- Uses a valid/ready request handshake, round-robin arbitration and an optional m1 lock for bursts.
- Drives registered memory commands and routes read data back to the requester that issued the read, strictly in order.
- Sits between the core execute stage, the loader and the data RAM.

Parameters:
- ADDR_W, 17, word-address width (131072 words).
- DATA_W, 32, data width.
- RD_LAT, 1, memory read latency in cycles from the mem_en cycle to valid mem_rdata; legal range 1..4.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- m0_req  in  1  core request valid
- m0_we  in  1  core: 1 = write, 0 = read
- m0_addr  in  ADDR_W  core word address
- m0_wdata  in  DATA_W  core write data
- m0_gnt  out  1  core request accepted this cycle (combinational)
- m0_rvalid  out  1  core read data valid
- m0_rdata  out  DATA_W  core read data
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as m0, for the loader
- m1_lock  in  1  loader holds ownership after the current grant
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data
- busy  out  1  any read in flight or any mem_en pending

Behaviour:
- Handshake: a request is accepted at a rising edge where mX_req and mX_gnt are both 1. While mX_req is high and not yet granted, the requester holds mX_we/addr/wdata stable. At most one gnt is high per cycle; gnt never asserts without req.
- Arbitration (combinational from req, prio, locked):
  - If locked = 1: only m1 can be granted.
  - Else if only one requester asserts req: that one wins.
  - Else if both assert req: prio selects the winner (0 -> m0, 1 -> m1).
- prio register: reset 0. On each accepted grant, prio <= index of the loser (the other port). Unchanged when idle.
- locked register: reset 0. Set on an accepted m1 grant with m1_lock = 1. Cleared on an accepted m1 grant with m1_lock = 0.
- Command stage (registered):
  - Cycle after acceptance: mem_en = 1, and mem_we/addr/wdata = the accepted fields.
  - No acceptance: mem_en = 0 and mem_we = 0; mem_addr/mem_wdata hold their last value.
  - Back-to-back acceptances give one access per cycle.
- Read return:
  - An (owner, is_read) tag pipeline of depth RD_LAT follows mem_en.
  - mX_rvalid pulses exactly RD_LAT cycles after the mem_en cycle of a read issued by X.
  - Both mX_rdata = mem_rdata, combinational pass-through (valid only while rvalid).
  - Writes never produce rvalid.
  - Total latency is 1 + RD_LAT cycles from the accept edge to rvalid.
  - Returns are in issue order; m0_rvalid and m1_rvalid are never high together.
- Ordering: accesses reach memory in acceptance order, so read-after-write to the same address returns the new data.
- Reset, in any state, asynchronously forces:
  - gnt = 0, mem_en = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0;
  - rvalid = 0 on both ports, busy = 0;
  - prio = 0, locked = 0, all tags cleared.
  In-flight reads are discarded with no rvalid after reset release.
- Boundaries:
  - Address wrap is the requester's responsibility; the arbiter passes addresses unmodified.
  - m1_lock is ignored on m1 reads/writes that are not accepted.
  - If m1 drops m1_req while locked, m0 is still blocked until m1 issues an accepted request with m1_lock = 0.

Test Plan:
- Reset, then m0 read addr 0x00010 (memory holds 0xDEADBEEF), RD_LAT=1 -> m0_gnt same cycle; mem_en next cycle with mem_addr=0x00010; m0_rvalid 2 cycles after accept with m0_rdata=0xDEADBEEF; m1_rvalid stays 0.
- Both requesters hold req continuously for 6 cycles -> grants alternate m0,m1,m0,m1,m0,m1 (prio 0 at reset); mem_en high for 6 consecutive cycles.
- m1 writes 0x12345678 to addr 0x1FFFF, then m0 reads 0x1FFFF on the next cycle -> m0_rdata = 0x12345678; no rvalid for the write.
- m1 issues 3 writes with m1_lock = 1, 1, 0 while m0_req is held high -> m0_gnt stays 0 until the third m1 grant; m0 is granted the following cycle.
- m0 read accepted, rst_n pulled low for 1 cycle before the return -> all outputs 0 immediately; no m0_rvalid after release; the next request is granted normally with prio = 0.
- RD_LAT=3, m0 read, m1 read, m0 read accepted back-to-back -> rvalid sequence m0, m1, m0 on three consecutive cycles starting 4 cycles after the first accept.
